// File: rtl/aes_pkg.sv
// Shared AES types: opcodes, round counts and the inverse-cipher controller state encoding.
package aes_pkg;

    typedef enum logic [2:0] {
        NOOP,
        AESENC,
        AESENCLAST,
        AESENCFULL,
        AESDEC,
        AESDECLAST,
        AESDECFULL
    } opcode;

    localparam int NR128 = 10;
    localparam int NR192 = 12;
    localparam int NR256 = 14;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SBOX,
        ROUND,
        DONE
    } dec_state_t;

    // A full-block decrypt needs the expanded schedule in place; single rounds bring their own key.
    function automatic logic dec_accept(input opcode op, input logic key_ready);
        return (op == AESDEC) || (op == AESDECLAST) || ((op == AESDECFULL) && key_ready);
    endfunction

endpackage

// File: rtl/aes_dec_ctrl_if.sv
// Request/strobe bundle between a requester (master) and the inverse-cipher controller (slave).
interface aes_dec_ctrl_if #(
    parameter int RW = 4
);
    import aes_pkg::*;

    logic          start_i;
    opcode         opcode_i;
    logic          key_ready_i;
    logic          busy_o;
    logic          load_o;
    logic          key_sel_o;
    logic          inv_sub_o;
    logic          add_key_o;
    logic          inv_mix_o;
    logic          final_rnd_o;
    logic [RW-1:0] rk_idx_o;
    logic          plain_ready_o;

    modport master (
        output start_i, opcode_i, key_ready_i,
        input  busy_o, load_o, key_sel_o, inv_sub_o, add_key_o,
               inv_mix_o, final_rnd_o, rk_idx_o, plain_ready_o
    );

    modport slave (
        input  start_i, opcode_i, key_ready_i,
        output busy_o, load_o, key_sel_o, inv_sub_o, add_key_o,
               inv_mix_o, final_rnd_o, rk_idx_o, plain_ready_o
    );

endinterface

// File: rtl/aes_rnd_cnt.sv
// Loadable round down-counter with zero flag; saturates at zero so it never wraps.
module aes_rnd_cnt #(
    parameter int            RW      = 4,
    parameter logic [RW-1:0] RST_VAL = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [RW-1:0] load_val,
    input  logic          dec,
    output logic [RW-1:0] cnt,
    output logic          zero
);

    assign zero = (cnt == '0);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= RST_VAL;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && !zero) begin
            cnt <= cnt - 1'b1;
        end
    end

endmodule

// File: rtl/aes_dec_ctrl.sv
// Inverse-cipher control FSM: sequences datapath strobes and round-key reads for AESDEC/AESDECLAST/AESDECFULL.
module aes_dec_ctrl
    import aes_pkg::*;
#(
    parameter int NR = 10,
    parameter int RW = 4
) (
    input  logic              clk,
    input  logic              rst,
    aes_dec_ctrl_if.slave     bus
);

    localparam logic [2:0] ST_IDLE  = IDLE;
    localparam logic [2:0] ST_LOAD  = LOAD;
    localparam logic [2:0] ST_SBOX  = SBOX;
    localparam logic [2:0] ST_ROUND = ROUND;
    localparam logic [2:0] ST_DONE  = DONE;

    logic [2:0]    state_q;
    logic [2:0]    state_d;
    opcode         op_q;
    logic          accept;
    logic          is_full;
    logic          cnt_load;
    logic          cnt_dec;
    logic [RW-1:0] rnd;
    logic          rnd_zero;

    assign accept  = (state_q == ST_IDLE) && bus.start_i && dec_accept(bus.opcode_i, bus.key_ready_i);
    assign is_full = (op_q == AESDECFULL);

    aes_rnd_cnt #(
        .RW      (RW),
        .RST_VAL (RW'(NR - 1))
    ) u_rnd_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (RW'(NR - 1)),
        .dec      (cnt_dec),
        .cnt      (rnd),
        .zero     (rnd_zero)
    );

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d  = state_q;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d  = ST_LOAD;
                    cnt_load = (bus.opcode_i == AESDECFULL);
                end
            end
            ST_LOAD:  state_d = ST_SBOX;
            ST_SBOX:  state_d = ST_ROUND;
            ST_ROUND: begin
                if (is_full && !rnd_zero) begin
                    cnt_dec = 1'b1;
                    state_d = ST_SBOX;
                end else begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            op_q    <= NOOP;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q <= bus.opcode_i;
            end
        end
    end

    // Outside SBOX/ROUND the store is pointed at rk[NR], so it is already valid when LOAD adds it.
    assign bus.busy_o        = (state_q != ST_IDLE);
    assign bus.load_o        = (state_q == ST_LOAD);
    assign bus.inv_sub_o     = (state_q == ST_SBOX);
    assign bus.add_key_o     = (state_q == ST_ROUND) || ((state_q == ST_LOAD) && is_full);
    assign bus.key_sel_o     = !is_full && ((state_q == ST_LOAD) || (state_q == ST_ROUND));
    assign bus.inv_mix_o     = (state_q == ST_ROUND) && (is_full ? !rnd_zero : (op_q == AESDEC));
    assign bus.final_rnd_o   = (state_q == ST_ROUND) && (is_full ? rnd_zero : (op_q == AESDECLAST));
    assign bus.plain_ready_o = (state_q == ST_DONE);
    assign bus.rk_idx_o      = ((state_q == ST_SBOX) || (state_q == ST_ROUND)) ? rnd : RW'(NR);

endmodule

// File: tb/tb_aes_dec_ctrl.sv
// Scoreboard bench for aes_dec_ctrl at NR=10/12/14, driven by shared random and directed stimulus.
module tb_aes_dec_ctrl;
    import aes_pkg::*;

    // strb bit order: load, key_sel, inv_sub, add_key, inv_mix, final_rnd, plain_ready
    typedef struct packed {
        logic [6:0] strb;
        logic [3:0] rk;
        logic       rk_care;
        logic       ks_care;
    } exp_t;

    logic  clk = 1'b0;
    logic  rst;
    logic  start_r;
    opcode op_r;
    logic  kr_r;
    bit    mon_en = 1'b0;
    int    checks = 0;
    int    failures = 0;

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic ld, input logic ks, input logic sb, input logic ak,
                                input logic im, input logic fr, input logic pr,
                                input int rk, input logic rkc, input logic ksc);
        exp_t e;
        e.strb    = {ld, ks, sb, ak, im, fr, pr};
        e.rk      = 4'(rk);
        e.rk_care = rkc;
        e.ks_care = ksc;
        return e;
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_nr
        localparam int NRG = NR128 + 2 * g;

        aes_dec_ctrl_if #(.RW(4)) bus ();
        assign bus.start_i     = start_r;
        assign bus.opcode_i    = op_r;
        assign bus.key_ready_i = kr_r;

        aes_dec_ctrl #(.NR(NRG), .RW(4)) dut (
            .clk (clk),
            .rst (rst),
            .bus (bus)
        );

        exp_t exp_q[$];
        int   rem = 0;
        int   cyc = 0;
        int   acc_cyc = 0;
        int   exp_lat = 0;

        // Reference model: per accepted request, the full list of per-cycle outputs while busy.
        always @(posedge clk) begin
            cyc++;
            if (rst) begin
                exp_q.delete();
                rem = 0;
            end else if (rem > 0) begin
                rem--;
            end else if (start_r && (op_r == AESDEC || op_r == AESDECLAST ||
                                     (op_r == AESDECFULL && kr_r))) begin
                if (op_r == AESDECFULL) begin
                    exp_q.push_back(mk(1, 0, 0, 1, 0, 0, 0, NRG, 1, 1));
                    for (int r = NRG - 1; r >= 0; r--) begin
                        exp_q.push_back(mk(0, 0, 1, 0, 0, 0, 0, r, 1, 0));
                        exp_q.push_back(mk(0, 0, 0, 1, r != 0, r == 0, 0, r, 1, 1));
                    end
                    rem     = 2 * NRG + 2;
                    exp_lat = 2 * NRG + 1;
                end else begin
                    exp_q.push_back(mk(1, 1, 0, 0, 0, 0, 0, NRG, 1, 1));
                    exp_q.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
                    exp_q.push_back(mk(0, 1, 0, 1, op_r == AESDEC, op_r == AESDECLAST, 0, 0, 0, 1));
                    rem     = 4;
                    exp_lat = 3;
                end
                exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
                acc_cyc = cyc;
            end
        end

        always @(negedge clk) begin : mon
            exp_t        e;
            logic [10:0] act;
            logic [10:0] mask;
            if (mon_en) begin
                act = {bus.rk_idx_o, bus.load_o, bus.key_sel_o, bus.inv_sub_o, bus.add_key_o,
                       bus.inv_mix_o, bus.final_rnd_o, bus.plain_ready_o};
                if (bus.busy_o) begin
                    if (exp_q.size() == 0) begin
                        check($sformatf("nr%0d_unexpected_busy", NRG), 32'(bus.busy_o), 32'd0);
                    end else begin
                        e    = exp_q.pop_front();
                        mask = {{4{e.rk_care}}, 1'b1, e.ks_care, 5'h1f};
                        check($sformatf("nr%0d_busy_outputs", NRG), 32'(act & mask),
                              32'({e.rk, e.strb} & mask));
                        if (bus.plain_ready_o) begin
                            check($sformatf("nr%0d_latency", NRG), 32'(cyc - acc_cyc), 32'(exp_lat));
                        end
                    end
                end else begin
                    check($sformatf("nr%0d_idle_outputs", NRG), 32'(act), 32'({4'(NRG), 7'b0}));
                    check($sformatf("nr%0d_missed_start", NRG), 32'(exp_q.size()), 32'd0);
                end
            end
        end
    end

    task automatic step(input logic s, input opcode o, input logic k, input logic r);
        start_r = s;
        op_r    = o;
        kr_r    = k;
        rst     = r;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic  s;
        logic  k;
        logic  r;
        opcode o;
        rst     = 1'b1;
        start_r = 1'b0;
        op_r    = NOOP;
        kr_r    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        mon_en = 1'b1;
        step(0, NOOP, 0, 1);
        step(0, NOOP, 0, 0);

        // Requests that must be ignored
        step(1, AESDECFULL, 0, 0);
        step(1, AESENC, 1, 0);
        step(1, AESENCFULL, 1, 0);
        step(1, NOOP, 1, 0);
        step(0, AESDEC, 1, 0);

        // Single round AESDEC
        step(1, AESDEC, 1, 0);
        repeat (5) step(0, NOOP, 1, 0);

        // Full block decrypt
        step(1, AESDECFULL, 1, 0);
        repeat (32) step(0, NOOP, 0, 0);

        // start held high while busy, then AESDECLAST back-to-back
        step(1, AESDECFULL, 1, 0);
        repeat (40) step(1, AESDECLAST, 1, 0);
        repeat (6) step(0, NOOP, 1, 0);

        // Reset for two cycles in the middle of a full block
        step(1, AESDECFULL, 1, 0);
        repeat (9) step(0, NOOP, 1, 0);
        repeat (2) step(0, NOOP, 1, 1);
        repeat (35) step(0, NOOP, 1, 0);

        // Random traffic
        repeat (400) begin
            s = ($urandom_range(0, 2) == 0);
            o = opcode'($urandom_range(0, 6));
            k = ($urandom_range(0, 3) != 0);
            r = ($urandom_range(0, 199) == 0);
            step(s, o, k, r);
        end
        repeat (40) step(0, NOOP, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
